// File: rtl/fp_accumulator_pkg.sv
// fp_accumulator_pkg: shared FSM state type and single-precision field constants.
package fp_accumulator_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
  localparam int FP_W = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam logic [7:0] EXP_INF = 8'hFF;
endpackage

// File: rtl/fp_accumulator_if.sv
// fp_accumulator_if: element stream in, result out, valid/ready on both sides.
interface fp_accumulator_if
  import fp_accumulator_pkg::*;
#(parameter int COUNT_W = 8);
  logic in_valid;
  logic in_ready;
  logic [FP_W-1:0] in_data;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [FP_W-1:0] out_sum;
  logic out_overflow;
  logic [COUNT_W-1:0] out_count;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input in_ready, out_valid, out_sum, out_overflow, out_count
  );
  modport slave (
    input in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_overflow, out_count
  );
endinterface

// File: rtl/fp_accumulator_adder.sv
// floatPointAdder: combinational single-precision add, round-to-nearest-even,
// subnormals flushed to zero; any 0xFF exponent returns 0 with ovf_o set.
module floatPointAdder
  import fp_accumulator_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic [FP_W-1:0] sum_o,
  output logic            ovf_o
);
  logic [FP_W-1:0] x, y;
  logic [23:0] mx, my;
  logic [7:0] d;
  logic [55:0] ysh;
  logic [26:0] al, n;
  logic [27:0] s;
  logic [4:0] lz;
  logic signed [9:0] e;
  logic [24:0] mr;
  logic found;
  always_comb begin
    x = (b_i[30:0] > a_i[30:0]) ? b_i : a_i;
    y = (b_i[30:0] > a_i[30:0]) ? a_i : b_i;
    mx = (x[EXP_MSB:EXP_LSB] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    my = (y[EXP_MSB:EXP_LSB] == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
    d = x[EXP_MSB:EXP_LSB] - y[EXP_MSB:EXP_LSB];
    ysh = {my, 32'd0} >> ((d > 8'd31) ? 8'd31 : d);
    // aligned operand keeps guard, round and a sticky bit below the mantissa
    al = {ysh[55:30], |ysh[29:0]};
    s = (x[31] ^ y[31]) ? {1'b0, mx, 3'b000} - {1'b0, al} : {1'b0, mx, 3'b000} + {1'b0, al};
    lz = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--)
      if (!found && s[i]) begin
        lz = 5'(26 - i);
        found = 1'b1;
      end
    e = {2'b00, x[EXP_MSB:EXP_LSB]};
    n = s[27] ? {s[27:2], s[1] | s[0]} : s[26:0] << lz;
    e = s[27] ? e + 10'sd1 : e - $signed({5'd0, lz});
    mr = {1'b0, n[26:3]} + {24'd0, n[2] & (n[3] | n[1] | n[0])};
    e = mr[24] ? e + 10'sd1 : e;
    ovf_o = (x[EXP_MSB:EXP_LSB] == EXP_INF) | (y[EXP_MSB:EXP_LSB] == EXP_INF) | (e >= 10'sd255);
    sum_o = (ovf_o || s == 28'd0 || e <= 10'sd0) ? '0 : {x[31], e[7:0], mr[24] ? mr[23:1] : mr[22:0]};
  end
endmodule

// File: rtl/fp_accumulator.sv
// fp_accumulator: sums a stream of single-precision elements into one result per in_last.
module fp_accumulator
  import fp_accumulator_pkg::*;
#(parameter int COUNT_W = 8)
(
  input logic clk,
  input logic rst,
  fp_accumulator_if.slave bus
);
  state_e state_q, state_d;
  logic [FP_W-1:0] acc_q, acc_d, add_sum;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, add_ovf, accept, idle;
  floatPointAdder u_add (.a_i(acc_q), .b_i(bus.in_data), .sum_o(add_sum), .ovf_o(add_ovf));
  assign idle = state_q == IDLE;
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.in_ready = state_q != DONE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_sum = acc_q;
  assign bus.out_overflow = ovf_q;
  assign bus.out_count = cnt_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (accept) begin
      state_d = bus.in_last ? DONE : ACC;
      acc_d = idle ? bus.in_data : add_sum;
      cnt_d = idle ? COUNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + COUNT_W'(1));
      ovf_d = idle ? (bus.in_data[EXP_MSB:EXP_LSB] == EXP_INF) : (ovf_q | add_ovf);
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: directed streams with hand-computed sums, counts and flags.
module tb_fp_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  fp_accumulator_if #(.COUNT_W(8)) bus ();
  fp_accumulator_if #(.COUNT_W(2)) bus2 ();
  fp_accumulator #(.COUNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  fp_accumulator #(.COUNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic send(input logic [31:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    chk("in_ready_stream", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic result(input string tag, input logic [31:0] sum, input logic [7:0] cnt, input logic ovf);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"}, bus.out_sum, sum);
    chk({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
    chk({tag, "_ovf"}, 32'(bus.out_overflow), 32'(ovf));
  endtask
  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("take_valid", 32'(bus.out_valid), 32'd0);
    chk("take_ready", 32'(bus.in_ready), 32'd1);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0; bus2.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_sum", bus.out_sum, 32'h0);
    chk("rst_ovf", 32'(bus.out_overflow), 32'd0);
    chk("rst_count", 32'(bus.out_count), 32'd0);
    send(32'h3F800000, 1'b0);
    chk("t1_mid_valid", 32'(bus.out_valid), 32'd0);
    send(32'h40000000, 1'b1);
    result("t1", 32'h40400000, 8'd2, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 32'h41200000; bus.in_last = 1'b1;
    take();
    bus.in_valid = 1'b0;
    chk("handshake_no_accept_count", 32'(bus.out_count), 32'd2);
    chk("handshake_no_accept_sum", bus.out_sum, 32'h40400000);
    send(32'h3FC00000, 1'b0);
    send(32'hBF000000, 1'b1);
    result("t2", 32'h3F800000, 8'd2, 1'b0);
    take();
    send(32'h3F800000, 1'b0);
    send(32'h7F800000, 1'b0);
    send(32'h3F800000, 1'b1);
    result("t3", 32'h3F800000, 8'd3, 1'b1);
    take();
    send(32'h7F800000, 1'b1);
    result("load_inf", 32'h7F800000, 8'd1, 1'b1);
    take();
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b1);
    result("ovf_cleared", 32'h40000000, 8'd2, 1'b0);
    take();
    send(32'h40A00000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
      result("hold", 32'h40A00000, 8'd1, 1'b0);
      @(posedge clk);
      #1;
    end
    take();
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    @(posedge clk);
    #1;
    chk("acc_idle_ready", 32'(bus.in_ready), 32'd1);
    chk("acc_idle_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 32'h40400000; bus.in_last = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_acc_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_acc_count", 32'(bus.out_count), 32'd0);
    chk("rst_acc_sum", bus.out_sum, 32'h0);
    chk("rst_acc_ready", 32'(bus.in_ready), 32'd1);
    send(32'h3F800000, 1'b1);
    result("after_rst", 32'h3F800000, 8'd1, 1'b0);
    take();
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data = 32'h0;
      bus2.in_last = (i == 4);
      chk("sat_ready", 32'(bus2.in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0;
    chk("sat_valid", 32'(bus2.out_valid), 32'd1);
    chk("sat_count", 32'(bus2.out_count), 32'd3);
    chk("sat_sum", bus2.out_sum, 32'h0);
    chk("sat_ovf", 32'(bus2.out_overflow), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_accumulator.md
FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 Parameter: COUNT_W, 8, width of the element counter; the counter saturates at 2^COUNT_W-1.
REQ-002 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  in_data/in_last carry a valid element.
REQ-005 in_ready  output  1  block accepts an element this cycle.
REQ-006 in_data  input  32  IEEE-754 single-precision operand.
REQ-007 in_last  input  1  element is the final one of the current sum.
REQ-008 out_valid  output  1  out_sum/out_overflow/out_count hold a completed result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_sum  output  32  accumulated single-precision sum.
REQ-011 out_overflow  output  1  sticky flag: some addition in this sum saw an exponent of 0xFF.
REQ-012 out_count  output  COUNT_W  number of elements accepted in this sum, saturating.

Function
REQ-013 The block SHALL be an FSM with states IDLE, ACC and DONE.
REQ-014 An element is accepted on a cycle where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-016 out_valid SHALL be 1 only in DONE.
REQ-017 IDLE accept: acc <= in_data (direct load, no addition); count <= 1; ovf <= (in_data[30:23]==8'hFF).
REQ-017a IDLE accept: next state is DONE if in_last is 1, otherwise ACC.
REQ-018 ACC accept: acc <= sum from the adder sub-module with A=acc, B=in_data; count <= count+1, saturating; ovf <= ovf OR adder overflow.
REQ-018a ACC accept: next state is DONE if in_last is 1, otherwise ACC.
REQ-019 One element per cycle, no bubbles: when in_valid is held at 1, in_ready SHALL stay 1 until the in_last element is accepted.
REQ-020 Latency: out_valid SHALL rise on the cycle after the in_last element is accepted.
REQ-021 In DONE, out_sum = acc, out_overflow = ovf and out_count = count; these SHALL stay stable while out_ready is 0.
REQ-022 In DONE with out_ready=1: next state is IDLE; acc, count and ovf are unchanged until the next load.
REQ-023 A new element is not accepted in the same cycle as the out_ready handshake; the earliest next accept is the following cycle.
REQ-024 When an addition overflows, the adder returns 0. acc SHALL take that 0 and ovf SHALL stay set until the next IDLE load.
REQ-025 The count saturates at 2^COUNT_W-1; further accepts SHALL leave it unchanged and SHALL still update acc.
REQ-026 In ACC with in_valid=0, acc, count and ovf SHALL hold.

Reset
REQ-027 rst=1 SHALL force, on the next edge: state=IDLE, acc=0, count=0, ovf=0.
REQ-027a The resulting outputs are out_valid=0, in_ready=1, out_sum=0, out_overflow=0 and out_count=0.
REQ-028 rst SHALL take priority over any handshake on the same edge.
REQ-029 Reset during ACC or DONE SHALL discard the partial sum or pending result; nothing is emitted.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, ACC, DONE).
REQ-030a The same package SHALL hold the constants FP_W=32, EXP_MSB=30, EXP_LSB=23 and EXP_INF=8'hFF.
REQ-031 The block SHALL instantiate the existing combinational single-precision adder, floatPointAdder, as its only sub-module.
REQ-031a That instance SHALL be driven by acc and in_data; no other arithmetic is duplicated.

Verification
REQ-032 Stream 0x3F800000, 0x40000000(last) -> out_sum=0x40400000, count=2, overflow=0, out_valid on the cycle after the last accept.
REQ-033 Stream 0x3FC00000, 0xBF000000(last) -> out_sum=0x3F800000, count=2, overflow=0.
REQ-034 Stream 0x3F800000, 0x7F800000, 0x3F800000(last) -> out_overflow=1, count=3, out_sum=0x3F800000 (zero from the overflowed add, plus 1.0).
REQ-035 Single element 0x40A00000(last); hold out_ready=0 for 5 cycles -> in_ready=0 and outputs stable throughout.
REQ-035a Then assert out_ready=1 -> IDLE on the next cycle and in_ready=1.
REQ-036 Assert rst=1 after 2 accepts in ACC -> next cycle: IDLE, out_valid=0, count=0.
REQ-036a Then stream 0x3F800000(last) -> out_sum=0x3F800000, count=1.
REQ-037 COUNT_W=2, stream five 0x00000000 elements, last on the fifth -> out_count=3, out_sum=0x00000000.
